subsys_reset_initiator: RTL

Initiator side of the subsystem reset handshake, clocked by `sys_clk`. On a single-cycle `start`, it asserts a reset request to a downstream subsystem, such as the PCIe user logic or the HBM traffic block. It then waits for the subsystem to acknowledge entry into reset, holds reset for a minimum time, releases it, and waits for the subsystem to report ready. It reports completion or a coded error, and keeps a saturating count of completed resets for CSR readback.

---
 rtl/subsys_reset_initiator_if.sv | 24 ++
 rtl/subsys_reset_initiator.sv | 129 ++++++++++++
 2 files changed

// File: rtl/subsys_reset_initiator_if.sv
// Request/CSR and subsystem-side handshake of the reset initiator. Single-cycle start,
// no backpressure; master drives start and the subsystem responses, slave is the initiator.
interface subsys_reset_initiator_if;
  logic        start;
  logic        req_ready;
  logic        busy;
  logic        rst_req;
  logic        rst_ack;
  logic        sub_ready;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] reset_count;

  modport master (
    output start, rst_ack, sub_ready,
    input  req_ready, busy, rst_req, done, err, err_code, reset_count
  );

  modport slave (
    input  start, rst_ack, sub_ready,
    output req_ready, busy, rst_req, done, err, err_code, reset_count
  );
endinterface

// File: rtl/subsys_reset_initiator.sv
// Subsystem reset handshake initiator: rst_req one cycle after an accepted start, ack/ready seen
// 2 cycles late through synchronisers; start is only taken when req_ready=1, otherwise dropped.
module subsys_reset_initiator #(
  parameter logic [31:0] MIN_ASSERT_CYCLES  = 32'h00000040,
  parameter logic [31:0] ACK_TIMEOUT_CYCLES = 32'h00010000,
  parameter logic [31:0] COOLDOWN_CYCLES    = 32'h00000010
) (
  input logic                     sys_clk,
  input logic                     sys_reset,
  subsys_reset_initiator_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_HOLD,
    S_RELEASE,
    S_DONE,
    S_ERR,
    S_COOLDOWN
  } state_e;

  localparam logic [31:0] HOLD_LAST = MIN_ASSERT_CYCLES  - 32'd1;
  localparam logic [31:0] TMO_LAST  = ACK_TIMEOUT_CYCLES - 32'd1;
  localparam logic [31:0] COOL_LAST = COOLDOWN_CYCLES    - 32'd1;

  state_e      state_q, state_d;
  logic [31:0] cnt_q;
  logic [1:0]  ack_sync_q;
  logic [1:0]  rdy_sync_q;
  logic        ack_s;
  logic        sub_ready_s;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] reset_count_q;
  logic        req_ready_q;
  logic        busy_q;
  logic        rst_req_q;
  logic        done_q;
  logic        err_q;

  assign ack_s       = ack_sync_q[1];
  assign sub_ready_s = rdy_sync_q[1];

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_ASSERT;
          err_code_d = 2'b00;
        end
      end
      S_ASSERT: begin
        if (ack_s) begin
          state_d = S_HOLD;
        end else if (cnt_q == TMO_LAST) begin
          state_d    = S_ERR;
          err_code_d = 2'b01;
        end
      end
      S_HOLD: begin
        // A lost acknowledge beats the hold count finishing in the same cycle.
        if (!ack_s) begin
          state_d    = S_ERR;
          err_code_d = 2'b11;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!ack_s && sub_ready_s) begin
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          state_d    = S_ERR;
          err_code_d = 2'b10;
        end
      end
      S_DONE:     state_d = S_COOLDOWN;
      S_ERR:      state_d = S_COOLDOWN;
      S_COOLDOWN: begin
        if (cnt_q == COOL_LAST) begin
          state_d = S_IDLE;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ack_sync_q    <= '0;
      rdy_sync_q    <= '0;
      err_code_q    <= 2'b00;
      reset_count_q <= '0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      rst_req_q     <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      ack_sync_q <= {ack_sync_q[0], bus.rst_ack};
      rdy_sync_q <= {rdy_sync_q[0], bus.sub_ready};
      state_q    <= state_d;
      cnt_q      <= (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
      err_code_q <= err_code_d;
      if (state_d == S_DONE && reset_count_q != 16'hFFFF) begin
        reset_count_q <= reset_count_q + 16'd1;
      end
      req_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      rst_req_q   <= (state_d == S_ASSERT) || (state_d == S_HOLD);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_ERR);
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.busy        = busy_q;
  assign bus.rst_req     = rst_req_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.reset_count = reset_count_q;

endmodule
